// File: rtl/stack_pc_pkg.sv
// Shared types and parameter defaults for the stack_pc program counter.
package stack_pc_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_RET,
        OP_CALL,
        OP_LOAD,
        OP_BRANCH,
        OP_STEP,
        OP_IDLE
    } op_e;

    localparam int PC_W_DEF      = 8;
    localparam int STEP_W_DEF    = 3;
    localparam int DEPTH_DEF     = 4;
    localparam int RESET_VEC_DEF = 0;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO, DEPTH x W; push/pop take effect on the clock edge, zero-latency top read.
// Latency: push/pop visible next cycle; full/empty registered. Backpressure: push when full / pop when empty ignored.
// The caller is expected to check full/empty itself; the guards here only protect the count.
module pc_ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] push_dat_i,
    output logic [W-1:0] top_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;
    logic [IDX_W-1:0] wr_idx, top_idx;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~push_i & ~empty_q;
    assign wr_idx  = IDX_W'(cnt_q);
    assign top_idx = IDX_W'(cnt_q - CNT_W'(1));
    assign top_o   = mem_q[top_idx];
    assign full_o  = full_q;
    assign empty_o = empty_q;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CNT_W'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    // Entry contents are deliberately left out of reset; only the count is cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= push_dat_i;
        end
    end

endmodule

// File: rtl/stack_pc.sv
// Program counter with step/load/branch and a call/return stack; optional relative branch via STACK_PC_BRANCH_EN.
// Latency: every PC update lands on the next rising edge. Backpressure: none; call-when-full / ret-when-empty set sticky stack_err.
module stack_pc
    import stack_pc_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int STEP_W    = STEP_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int RESET_VEC = RESET_VEC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              hold,
    input  logic              load,
    input  logic [PC_W-1:0]   load_value,
    input  logic [STEP_W-1:0] step_size,
    input  logic              branch,
    input  logic [PC_W-1:0]   branch_offset,
    input  logic              call,
    input  logic              ret,
    output logic [PC_W-1:0]   pc_out,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err,
    output logic              wrap
);

    op_e             op;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            err_q, err_d;
    logic            wrap_q, wrap_d;
    logic            push, pop;
    logic [PC_W-1:0] top;
    logic [PC_W:0]   step_sum;

    assign step_sum = {1'b0, pc_q} + (PC_W + 1)'(step_size);

`ifdef STACK_PC_BRANCH_EN
    logic [PC_W:0] br_sum;
    assign br_sum = {1'b0, pc_q} + {1'b0, branch_offset};
`else
    logic unused_br;
    assign unused_br = ^{branch, branch_offset};
`endif

    always_comb begin
        if (hold) begin
            op = OP_HOLD;
        end else if (ret) begin
            op = OP_RET;
        end else if (call) begin
            op = OP_CALL;
        end else if (load) begin
            op = OP_LOAD;
`ifdef STACK_PC_BRANCH_EN
        end else if (branch) begin
            op = OP_BRANCH;
`endif
        end else if (enable) begin
            op = OP_STEP;
        end else begin
            op = OP_IDLE;
        end
    end

    always_comb begin
        pc_d   = pc_q;
        err_d  = err_q;
        wrap_d = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        case (op)
            OP_RET: begin
                if (!stack_empty) begin
                    pop  = 1'b1;
                    pc_d = top;
                end else begin
                    err_d = 1'b1;
                end
            end
            OP_CALL: begin
                if (!stack_full) begin
                    push = 1'b1;
                    pc_d = load_value;
                end else begin
                    err_d = 1'b1;
                end
            end
            OP_LOAD: pc_d = load_value;
`ifdef STACK_PC_BRANCH_EN
            // Negative offset wraps when there is no carry; positive wraps when there is.
            OP_BRANCH: begin
                pc_d   = br_sum[PC_W-1:0];
                wrap_d = branch_offset[PC_W-1] ^ br_sum[PC_W];
            end
`endif
            OP_STEP: begin
                pc_d   = step_sum[PC_W-1:0];
                wrap_d = step_sum[PC_W];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= PC_W'(RESET_VEC);
            err_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            err_q  <= err_d;
            wrap_q <= wrap_d;
        end
    end

    pc_ret_stack #(
        .DEPTH (DEPTH),
        .W     (PC_W)
    ) u_stack (
        .clk        (clk),
        .rst_n      (reset),
        .push_i     (push),
        .pop_i      (pop),
        .push_dat_i (step_sum[PC_W-1:0]),
        .top_o      (top),
        .full_o     (stack_full),
        .empty_o    (stack_empty)
    );

    assign pc_out    = pc_q;
    assign stack_err = err_q;
    assign wrap      = wrap_q;

endmodule

// File: doc/stack_pc.md
STACK_PC -- requirements
Module: stack_pc

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- PC_W, 8, PC and address width.
- STEP_W, 3, step_size width.
- DEPTH, 4, return-stack entries (>=1).
- RESET_VEC, 0, PC value on reset.
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  permits sequential stepping.
- hold  in  1  freezes PC and stack.
- load  in  1  absolute jump to load_value.
- load_value  in  PC_W  jump/call target.
- step_size  in  STEP_W  unsigned increment per step.
- branch  in  1  relative jump.
- branch_offset  in  PC_W  two's-complement offset.
- call  in  1  push return address, jump to load_value.
- ret  in  1  pop return address into PC.
- pc_out  out  PC_W  current PC, registered.
- stack_full  out  1  DEPTH entries held.
- stack_empty  out  1  no entries held.
- stack_err  out  1  sticky overflow/underflow flag.
- wrap  out  1  one-cycle pulse: last PC update wrapped modulo 2^PC_W.

Function
REQ-003 One operation per cycle SHALL be selected by fixed priority: hold > ret > call > load > branch > step.
REQ-004 hold=1 SHALL leave pc_out, stack contents, stack count and stack_err unchanged; wrap SHALL be 0.
REQ-005 Step: when enable=1 and no higher-priority op is active, pc_out SHALL become pc_out+step_size modulo 2^PC_W on the next edge; step_size=0 leaves PC unchanged.
REQ-006 enable=0 SHALL suppress stepping only; load, branch, call and ret SHALL still act.
REQ-007 Load: pc_out SHALL become load_value on the next edge.
REQ-008 Branch: pc_out SHALL become pc_out+sign-extended branch_offset modulo 2^PC_W.
REQ-009 Call with stack not full: push pc_out+step_size (mod 2^PC_W) and set pc_out to load_value in the same edge.
REQ-010 Ret with stack not empty: pc_out SHALL become the popped top entry in the same edge.
REQ-011 Call while full SHALL not push, SHALL leave pc_out unchanged and SHALL set stack_err.
REQ-012 Ret while empty SHALL leave pc_out unchanged and SHALL set stack_err.
REQ-013 call and ret asserted together: ret SHALL win; call SHALL be ignored with no error.
REQ-014 wrap SHALL pulse for one cycle when a step or branch carries/borrows past 2^PC_W; it SHALL be 0 for load, call and ret.
REQ-015 stack_full/stack_empty SHALL be registered and reflect the count after the current edge.
REQ-016 stack_err SHALL stay set until reset.

Reset
REQ-017 reset=0 SHALL asynchronously set pc_out=RESET_VEC, empty the stack, clear stack_err and wrap, and set stack_empty=1, stack_full=0; stack entry contents need not be cleared.
REQ-018 Reset asserted mid-operation SHALL discard any pending push/pop; the first edge after deassertion SHALL act normally.

Configuration
REQ-019 Macro STACK_PC_BRANCH_EN defined: relative branch per REQ-008. Undefined: branch and branch_offset SHALL be ignored (ports kept), and priority falls through to step.

Structure
REQ-020 Package stack_pc_pkg SHALL hold the operation-select enum (OP_HOLD, OP_RET, OP_CALL, OP_LOAD, OP_BRANCH, OP_STEP, OP_IDLE) and parameter defaults.
REQ-021 The return stack SHALL be a sub-module pc_ret_stack (LIFO, DEPTH x PC_W, push/pop/full/empty).

Verification (PC_W=8, STEP_W=3, DEPTH=4, RESET_VEC=0)
REQ-022 Reset release, enable=1, step_size=1 for 3 cycles, then 4 for 2 cycles -> pc_out 1,2,3,7,11.
REQ-023 pc_out=8'hFE, step_size=3 -> pc_out=8'h01 with a one-cycle wrap pulse; hold=1 for 2 cycles -> pc_out stays 8'h01.
REQ-024 pc_out=8'h10, step_size=2, call with load_value=8'h80 -> pc_out=8'h80; then ret -> pc_out=8'h12, stack_empty=1.
REQ-025 Five calls from empty -> stack_full after the 4th; 5th leaves pc_out unchanged and sets stack_err; ret on empty also sets stack_err, which persists until reset.
REQ-026 With STACK_PC_BRANCH_EN: pc_out=8'h05, branch_offset=8'hFA -> pc_out=8'hFF, wrap=1; without the macro, same stimulus with enable=1, step_size=1 -> pc_out=8'h06.
REQ-027 call and ret together with 1 entry (8'h40) -> pc_out=8'h40, stack_empty=1, stack_err=0; reset asserted mid-cycle -> pc_out=0 immediately.
